// File: rtl/out_channel_drain_if.sv
// Bundle of executor-side write signals and consumer-side drain stream for out_channel_drain.
// The slave modport is the drain block itself; master is whoever drives it.
interface out_channel_drain_if #(
  parameter int W    = 12,
  parameter int NOut = 100
);
  localparam int CW = $clog2(NOut + 1);

  logic          outWrite;
  logic [W-1:0]  outData;
  logic          vmFinished;
  logic          vmSuccess;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          drainValid;
  logic [W-1:0]  drainData;
  logic          drainLast;
  logic          drainReady;
  logic          done;
  logic          success;

  modport slave (
    input  outWrite, outData, vmFinished, vmSuccess, drainReady,
    output full, count, overflow, drainValid, drainData, drainLast, done, success
  );

  modport master (
    output outWrite, outData, vmFinished, vmSuccess, drainReady,
    input  full, count, overflow, drainValid, drainData, drainLast, done, success
  );
endinterface

// File: rtl/out_channel_drain.sv
// Buffers executor output words in a circular buffer and streams them out over valid/ready,
// followed by one trailer word {success, accepted-word count}.
module out_channel_drain #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 100
) (
  input logic                clock,
  input logic                reset,
  out_channel_drain_if.slave bus
);
  localparam int W  = MemoryElementWidth;
  localparam int CW = $clog2(NOut + 1);
  localparam int PW = $clog2(NOut);
  localparam logic [PW-1:0] LAST_PTR = PW'(NOut - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(NOut);

  localparam logic [1:0] S_STREAM  = 2'd0;
  localparam logic [1:0] S_TRAILER = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [W-1:0]  mem [NOut];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [W-2:0]  acc;
  logic [1:0]    state;
  logic          fin;
  logic          fin_next;
  logic          success_r;
  logic          overflow_r;
  logic          is_full;
  logic          wr_ok;
  logic          pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign is_full  = (cnt == FULL_CNT);
  // Space is judged on the registered count, so a same-cycle pop never rescues a write into a full buffer.
  assign wr_ok    = bus.outWrite && !fin && !is_full;
  assign pop      = (state == S_STREAM) && (cnt != '0) && bus.drainReady;
  assign fin_next = fin | bus.vmFinished;

  always_comb begin
    cnt_next = cnt;
    if (wr_ok && !pop)
      cnt_next = cnt + 1'b1;
    else if (pop && !wr_ok)
      cnt_next = cnt - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (wr_ok)
      mem[wptr] <= bus.outData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      cnt        <= '0;
      acc        <= '0;
      fin        <= 1'b0;
      success_r  <= 1'b0;
      overflow_r <= 1'b0;
      state      <= S_STREAM;
    end else begin
      if (wr_ok) begin
        wptr <= ptr_inc(wptr);
        acc  <= acc + 1'b1;
      end
      if (pop)
        rptr <= ptr_inc(rptr);
      cnt <= cnt_next;
      if (bus.outWrite && !fin && is_full)
        overflow_r <= 1'b1;
      if (!fin && bus.vmFinished) begin
        fin       <= 1'b1;
        success_r <= bus.vmSuccess;
      end
      // The trailer follows as soon as finish is known and the last buffered word has left.
      case (state)
        S_STREAM:  if (fin_next && cnt_next == '0) state <= S_TRAILER;
        S_TRAILER: if (bus.drainReady) state <= S_DONE;
        S_DONE:    state <= S_DONE;
        default:   state <= S_STREAM;
      endcase
    end
  end

  always_comb begin
    bus.drainData = '0;
    if (state == S_TRAILER)
      bus.drainData = {success_r, acc};
    else if (state == S_STREAM && cnt != '0)
      bus.drainData = mem[rptr];
  end

  assign bus.drainValid = (state == S_TRAILER) || (state == S_STREAM && cnt != '0);
  assign bus.drainLast  = (state == S_TRAILER);
  assign bus.done       = (state == S_DONE);
  assign bus.success    = success_r;
  assign bus.full       = is_full;
  assign bus.count      = cnt;
  assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_out_channel_drain.sv
// Randomized and directed bench for out_channel_drain, checked against a queue-based model
// of the word stream, trailer and sticky flags.
module tb_out_channel_drain;
  localparam int W    = 12;
  localparam int NOut = 4;

  logic clock;
  logic reset;
  int   test_count = 0;
  int   fail_count = 0;

  out_channel_drain_if #(.W(W), .NOut(NOut)) bus ();

  out_channel_drain #(.MemoryElementWidth(W), .NOut(NOut)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a word queue plus finish/trailer/done flags.
  logic [W-1:0] model_q[$];
  bit m_fin, m_succ, m_ovf, m_trailer, m_done;
  int m_acc;

  function automatic void modelReset();
    model_q.delete();
    m_fin = 0; m_succ = 0; m_ovf = 0; m_trailer = 0; m_done = 0; m_acc = 0;
  endfunction

  function automatic void modelStep(input bit ow, input logic [W-1:0] od, input bit vf, input bit vs, input bit rdy);
    int sz;
    sz = model_q.size();
    if (!m_trailer && !m_done && sz != 0 && rdy) void'(model_q.pop_front());
    if (m_trailer && rdy) begin m_trailer = 0; m_done = 1; end
    if (ow && !m_fin) begin
      if (sz == NOut) m_ovf = 1;
      else begin model_q.push_back(od); m_acc++; end
    end
    if (!m_fin && vf) begin m_fin = 1; m_succ = vs; end
    if (m_fin && !m_trailer && !m_done && model_q.size() == 0) m_trailer = 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    bit exp_valid;
    logic [W-1:0] exp_data;
    exp_valid = m_trailer || (!m_done && model_q.size() != 0);
    exp_data  = m_trailer ? {m_succ, 11'(m_acc)} : (model_q.size() != 0 ? model_q[0] : '0);
    checkOutput("drainValid", 32'(bus.drainValid), 32'(exp_valid));
    if (exp_valid) checkOutput("drainData", 32'(bus.drainData), 32'(exp_data));
    checkOutput("drainLast", 32'(bus.drainLast), 32'(m_trailer));
    checkOutput("full", 32'(bus.full), 32'(model_q.size() == NOut));
    checkOutput("count", 32'(bus.count), 32'(model_q.size()));
    checkOutput("overflow", 32'(bus.overflow), 32'(m_ovf));
    checkOutput("done", 32'(bus.done), 32'(m_done));
    checkOutput("success", 32'(bus.success), 32'(m_succ));
  endtask

  task automatic checkResetValues();
    checkOutput("rst_full", 32'(bus.full), 0);
    checkOutput("rst_count", 32'(bus.count), 0);
    checkOutput("rst_overflow", 32'(bus.overflow), 0);
    checkOutput("rst_drainValid", 32'(bus.drainValid), 0);
    checkOutput("rst_drainData", 32'(bus.drainData), 0);
    checkOutput("rst_drainLast", 32'(bus.drainLast), 0);
    checkOutput("rst_done", 32'(bus.done), 0);
    checkOutput("rst_success", 32'(bus.success), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.outWrite = 0; bus.outData = '0; bus.vmFinished = 0; bus.vmSuccess = 0; bus.drainReady = 0;
    modelReset();
    #1;
    checkResetValues();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input bit ow, input logic [W-1:0] od, input bit vf, input bit vs, input bit rdy);
    bus.outWrite = ow; bus.outData = od; bus.vmFinished = vf; bus.vmSuccess = vs; bus.drainReady = rdy;
    @(posedge clock);
    modelStep(ow, od, vf, vs, rdy);
    #1;
    checkAll();
  endtask

  logic [W-1:0] last_trailer;

  // Holds finish high and drains until done, remembering the trailer word seen on the bus.
  task automatic runDrain(input bit vs, input bit random_ready);
    int cycles;
    cycles = 0;
    last_trailer = '0;
    while (!bus.done && cycles < 200) begin
      if (bus.drainValid && bus.drainLast) last_trailer = bus.drainData;
      applyStimulus(1'b0, '0, 1'b1, vs, random_ready ? 1'($urandom % 2) : 1'b1);
      cycles++;
    end
    checkOutput("drain_done", 32'(bus.done), 1);
  endtask

  initial begin
    bit vs_run;
    int fin_at;
    reset = 1'b1;
    modelReset();

    // Basic stream and trailer
    doReset();
    applyStimulus(1, 12'd3, 0, 0, 1);
    applyStimulus(1, 12'd7, 0, 0, 1);
    applyStimulus(1, 12'd9, 0, 0, 1);
    runDrain(1'b1, 1'b0);
    checkOutput("t1_trailer", 32'(last_trailer), 32'h803);
    checkOutput("t1_success", 32'(bus.success), 1);

    // Fill then overflow
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1, 12'(i), 0, 0, 0);
    applyStimulus(1, 12'd5, 0, 0, 0);
    checkOutput("t2_full", 32'(bus.full), 1);
    checkOutput("t2_overflow", 32'(bus.overflow), 1);
    runDrain(1'b1, 1'b0);
    checkOutput("t2_trailer", 32'(last_trailer), 32'h804);

    // Stalling consumer across pointer wrap
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1, 12'(10 + i), 0, 0, 1'(i % 2));
    for (int i = 0; i < 8; i++) applyStimulus(0, '0, 0, 0, 1'(i % 2));
    runDrain(1'b1, 1'b1);
    checkOutput("t3_trailer", 32'(last_trailer), 32'h806);

    // Write after finish is ignored
    doReset();
    applyStimulus(1, 12'h0A1, 0, 0, 0);
    applyStimulus(1, 12'h0A2, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(1, 12'h0A3, 0, 1, 0);
    checkOutput("t4_overflow", 32'(bus.overflow), 0);
    checkOutput("t4_count", 32'(bus.count), 2);
    runDrain(1'b1, 1'b0);
    checkOutput("t4_trailer", 32'(last_trailer), 32'h002);
    checkOutput("t4_success", 32'(bus.success), 0);

    // Simultaneous write and pop, full and half-full
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1, 12'(i), 0, 0, 0);
    applyStimulus(1, 12'd5, 0, 0, 1);
    checkOutput("t5_count_full", 32'(bus.count), 3);
    checkOutput("t5_overflow", 32'(bus.overflow), 1);
    applyStimulus(0, '0, 0, 0, 1);
    applyStimulus(1, 12'd6, 0, 0, 1);
    checkOutput("t5_count_half", 32'(bus.count), 2);
    runDrain(1'b0, 1'b0);

    // Reset during the trailer, then a fresh one-word run
    doReset();
    applyStimulus(1, 12'h055, 1, 1, 0);
    applyStimulus(0, '0, 0, 0, 1);
    applyStimulus(0, '0, 0, 0, 0);
    checkOutput("t6_in_trailer", 32'(bus.drainLast), 1);
    #2;
    doReset();
    applyStimulus(1, 12'h0AB, 0, 0, 1);
    runDrain(1'b1, 1'b0);
    checkOutput("t6_trailer", 32'(last_trailer), 32'h801);

    // Randomized runs
    for (int run = 0; run < 30; run++) begin
      doReset();
      fin_at = $urandom_range(3, 25);
      vs_run = 1'($urandom % 2);
      for (int c = 0; c < 30; c++)
        applyStimulus(1'($urandom % 4 != 0), 12'($urandom), (c == fin_at),
                       (c == fin_at) ? vs_run : 1'($urandom % 2), 1'($urandom % 3 == 0));
      runDrain(vs_run, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end
endmodule
